// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer. Two debounced buttons select the pattern mode and the step speed.
// A prescaler produces step ticks that advance a one-hot LED register.
module led_pattern_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 24,
  parameter int DB_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             btn_mode,
  input  logic             btn_speed,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic [1:0]       speed,
  output logic             step
);

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam logic [WIDTH-1:0] LED_LSB = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;
  assign w_btn_raw = {btn_speed, btn_mode};

  // Index 0 is the mode button, index 1 the speed button.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_accept;

    assign w_accept   = (r_sync2 != r_level) && (&r_db_cnt);
    assign w_press[g] = w_accept && r_sync2;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_sync1  <= 1'b0;
        r_sync2  <= 1'b0;
        r_level  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_sync1 <= w_btn_raw[g];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end
  end

  logic             w_mode_press;
  logic             w_speed_press;
  assign w_mode_press  = w_press[0];
  assign w_speed_press = w_press[1];

  logic [WIDTH-1:0] r_led;
  mode_e            r_mode;
  logic [1:0]       r_speed;
  logic             r_step;
  dir_e             r_dir;
  logic [CNT_W-1:0] r_cnt;

  logic [CNT_W-1:0] w_mask;
  logic             w_tick;
  logic             w_onehot;
  logic [WIDTH-1:0] w_led_next;
  dir_e             w_dir_next;

  // Only the low CNT_W-2s bits must be all ones, so each speed step quarters the period.
  assign w_mask   = {CNT_W{1'b1}} >> {r_speed, 1'b0};
  assign w_tick   = enable && (&(r_cnt | ~w_mask)) && !w_speed_press;
  assign w_onehot = (r_led != '0) && ((r_led & (r_led - LED_LSB)) == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_led_next = r_led;
    w_dir_next = r_dir;
    if (!w_onehot) begin
      w_led_next = LED_LSB;
    end else begin
      case (r_mode)
        MODE_LEFT:  w_led_next = r_led[WIDTH-1] ? LED_LSB : (r_led << 1);
        MODE_RIGHT: w_led_next = r_led[0] ? LED_MSB : (r_led >> 1);
        MODE_BOUNCE: begin
          if (r_dir == DIR_UP) begin
            if (r_led[WIDTH-1]) begin
              w_dir_next = DIR_DOWN;
              w_led_next = r_led >> 1;
            end else begin
              w_led_next = r_led << 1;
            end
          end else begin
            if (r_led[0]) begin
              w_dir_next = DIR_UP;
              w_led_next = r_led << 1;
            end else begin
              w_led_next = r_led >> 1;
            end
          end
        end
        MODE_HOLD:  w_led_next = r_led;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_speed_press) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_led   <= LED_LSB;
      r_mode  <= MODE_LEFT;
      r_speed <= 2'd0;
      r_step  <= 1'b0;
      r_dir   <= DIR_UP;
    end else begin
      r_step <= 1'b0;
      if (w_tick) begin
        r_led  <= w_led_next;
        r_dir  <= w_dir_next;
        r_step <= (w_led_next != r_led);
      end
      // The tick above already used the pre-press mode; entering BOUNCE restarts upward.
      if (w_mode_press) begin
        r_mode <= mode_e'(r_mode + 2'd1);
        if (r_mode == MODE_RIGHT) begin
          r_dir <= DIR_UP;
        end
      end
      if (w_speed_press) begin
        r_speed <= r_speed + 2'd1;
      end
    end
  end

  assign led   = r_led;
  assign mode  = r_mode;
  assign speed = r_speed;
  assign step  = r_step;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random button/enable traffic,
// compared every cycle against a position-based model of the LED pattern.
module tb_led_pattern_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = 8;
  localparam int DB_W  = 2;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         btn_mode;
  logic         btn_speed;
  logic [W-1:0] led;
  logic [1:0]   mode;
  logic [1:0]   speed;
  logic         step;

  led_pattern_ctrl #(.WIDTH(W), .CNT_W(CNT_W), .DB_W(DB_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .btn_mode  (btn_mode),
    .btn_speed (btn_speed),
    .led       (led),
    .mode      (mode),
    .speed     (speed),
    .step      (step)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Model: LED as a lit position, bounce as a phase on a triangle wave of length 2W-2.
  int       m_cnt;
  int       m_speed;
  int       m_mode;
  int       m_pos;
  int       m_bph;
  bit       m_legal;
  bit [W-1:0] m_bad_led;
  bit       m_step;
  int       mode_cd;
  int       speed_cd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tri_pos(input int ph);
    return (ph < W) ? ph : (2 * W - 2 - ph);
  endfunction

  function automatic logic [31:0] exp_led();
    bit [W-1:0] v;
    v = m_legal ? W'(1 << m_pos) : m_bad_led;
    return 32'(v);
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_speed  = 0;
    m_mode   = 0;
    m_pos    = 0;
    m_bph    = 0;
    m_legal  = 1'b1;
    m_step   = 1'b0;
    mode_cd  = 0;
    speed_cd = 0;
  endtask

  task automatic model_edge(input bit mp, input bit sp, input bit en);
    int  period;
    int  old_pos;
    bit  tick;
    period = 1 << (CNT_W - 2 * m_speed);
    tick   = en && ((m_cnt % period) == period - 1) && !sp;
    m_step = 1'b0;
    if (tick) begin
      old_pos = m_pos;
      if (!m_legal) begin
        m_pos   = 0;
        m_legal = 1'b1;
        m_step  = 1'b1;
      end else begin
        case (m_mode)
          0: m_pos = (m_pos + 1) % W;
          1: m_pos = (m_pos + W - 1) % W;
          2: begin
            m_bph = (m_bph + 1) % (2 * W - 2);
            m_pos = tri_pos(m_bph);
          end
          default: ;
        endcase
        m_step = (m_pos != old_pos);
      end
    end
    if (mp) begin
      m_mode = (m_mode + 1) % 4;
      if (m_mode == 2) m_bph = m_pos;
    end
    if (sp) begin
      m_speed = (m_speed + 1) % 4;
      m_cnt   = 0;
    end else if (en) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      bit mp;
      bit sp;
      @(posedge clock);
      mp = (mode_cd == 1);
      sp = (speed_cd == 1);
      if (mode_cd > 0) mode_cd--;
      if (speed_cd > 0) speed_cd--;
      model_edge(mp, sp, enable);
      #1;
      check("led", led, exp_led());
      check("step", step, 32'(m_step));
      check("mode", mode, 32'(m_mode));
      check("speed", speed, 32'(m_speed));
    end
  endtask

  // A held button is accepted on the 6th edge: 2 synchroniser + 4 debounce cycles.
  task automatic press(input bit pm, input bit ps);
    if (pm) begin
      btn_mode = 1'b1;
      mode_cd  = 6;
    end
    if (ps) begin
      btn_speed = 1'b1;
      speed_cd  = 6;
    end
    cyc(10);
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    cyc(8);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    btn_mode  = 1'b0;
    btn_speed = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst_led", led, 32'h01);
    check("rst_mode", mode, 32'h0);
    check("rst_speed", speed, 32'h0);
    check("rst_step", step, 32'h0);
    reset  = 1'b0;
    enable = 1'b1;

    // Left shift at 256-cycle period
    cyc(255);
    check("t1_before_tick", led, 32'h01);
    cyc(1);
    check("t1_first_tick", led, 32'h02);
    check("t1_first_step", step, 32'h1);
    cyc(256 * 6);
    check("t1_msb", led, 32'h80);
    cyc(256);
    check("t1_wrap", led, 32'h01);

    // Mode press to RIGHT, then 01 -> 80 -> 40
    press(1'b1, 1'b0);
    check("t2_mode_right", mode, 32'h1);
    cyc(238);
    check("t2_right_wrap", led, 32'h80);
    cyc(256);
    check("t2_right_shift", led, 32'h40);

    // Walk down to 01, then BOUNCE through both ends
    cyc(256 * 6);
    check("t3_at_lsb", led, 32'h01);
    press(1'b1, 1'b0);
    check("t3_mode_bounce", mode, 32'h2);
    cyc(238);
    check("t3_b_02", led, 32'h02);
    cyc(256 * 6);
    check("t3_b_top", led, 32'h80);
    cyc(256 * 7);
    check("t3_b_bottom", led, 32'h01);
    cyc(256);
    check("t3_b_rise", led, 32'h02);

    // Speed press: prescaler restarts, 64-cycle period
    press(1'b0, 1'b1);
    check("t4_speed1", speed, 32'h1);
    cyc(51);
    check("t4_no_tick_yet", led, 32'h02);
    cyc(1);
    check("t4_tick64", led, 32'h04);
    check("t4_step64", step, 32'h1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("t4_speed_wrap", speed, 32'h0);
    cyc(300);

    // Glitch rejection and frozen enable
    btn_mode = 1'b1;
    cyc(2);
    btn_mode = 1'b0;
    cyc(10);
    check("t5_glitch_mode", mode, 32'h2);
    enable = 1'b0;
    cyc(1000);
    enable = 1'b1;
    cyc(20);

    // Random traffic
    for (int k = 0; k < 24; k++) begin
      int act;
      act = $urandom_range(0, 5);
      case (act)
        0: press(1'b1, 1'b0);
        1: press(1'b0, 1'b1);
        2: press(1'b1, 1'b1);
        3: begin
          enable = 1'b0;
          cyc($urandom_range(5, 200));
          press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
          enable = 1'b1;
        end
        default: cyc($urandom_range(10, 600));
      endcase
    end
    // Make sure the mid-period reset starts from a non-reset state
    if (m_mode == 0) press(1'b1, 1'b0);
    cyc(37);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_led", led, 32'h01);
    check("t6_async_mode", mode, 32'h0);
    check("t6_async_speed", speed, 32'h0);
    check("t6_async_step", step, 32'h0);
    reset = 1'b0;
    model_reset();
    cyc(3);

    // Illegal pattern recovers on the next tick
    force dut.r_led = 8'h03;
    #1;
    release dut.r_led;
    m_legal   = 1'b0;
    m_bad_led = 8'h03;
    check("t6_forced", led, 32'h03);
    cyc(253);
    check("t6_recover", led, 32'h01);
    check("t6_recover_step", step, 32'h1);
    cyc(256);
    check("t6_after", led, 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
